rv8_alu_issue_stage: RTL and testbench

- Issue stage directly upstream of the 8-bit ALU (aluV_8).
- Accepts 32-bit RV32 R/I-type instructions over a valid/ready handshake and reads operands from a 32 x 8-bit register file with x0 hardwired to zero.
- Decodes each instruction to the ALU's 4-bit ALUctrl code and presents ALUctrl/A/B/rd from one pipeline register.
- The ALU result returns through a write-back port that updates the register file.

---
 rtl/rv8_alu_pkg.sv | 23 ++
 rtl/rv8_alu_issue_stage_regfile.sv | 38 +++
 rtl/rv8_alu_issue_stage.sv | 145 ++++++++++++++
 tb/tb_rv8_alu_issue_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv8_alu_pkg.sv
// Shared constants for the RV32-subset issue stage feeding the 8-bit ALU.
package rv8_alu_pkg;
  localparam int XLEN_DEFAULT = 8;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_NOR     = 4'd12;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
endpackage

// File: rtl/rv8_alu_issue_stage_regfile.sv
// 32 x XLEN register file: x0 reads zero, two async reads with write-first bypass.
module rv8_regfile
  import rv8_alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-cycle write to the register being read wins over the stored value.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (we && waddr == rs1_addr) rs1_data = wdata;
    if (we && waddr == rs2_addr) rs2_data = wdata;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end
endmodule

// File: rtl/rv8_alu_issue_stage.sv
// Issue stage: decodes RV32 R/I ops to ALUctrl, reads operands, holds them in one register.
// Optional macro RV8_ISSUE_STATS_EN adds saturating issued/illegal transfer counters.
module rv8_alu_issue_stage
  import rv8_alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALUctrl,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [4:0]      rd,
  output logic            illegal
`ifdef RV8_ISSUE_STATS_EN
  ,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     illegal_cnt
`endif
);
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  rv8_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_en),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  logic [3:0]      dec_ctrl;
  logic            dec_ok, dec_imm;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;

  always_comb begin
    dec_ctrl = ALU_ILLEGAL;
    dec_ok   = 1'b0;
    dec_imm  = 1'b0;
    case (opcode)
      OP_R: begin
        case (f3)
          F3_ADDSUB: begin
            if (f7 == F7_BASE) begin dec_ctrl = ALU_ADD; dec_ok = 1'b1; end
            else if (f7 == F7_ALT) begin dec_ctrl = ALU_SUB; dec_ok = 1'b1; end
          end
          F3_AND: if (f7 == F7_BASE) begin dec_ctrl = ALU_AND; dec_ok = 1'b1; end
          F3_OR:  if (f7 == F7_BASE) begin dec_ctrl = ALU_OR;  dec_ok = 1'b1; end
          F3_SLT: if (f7 == F7_BASE) begin dec_ctrl = ALU_SLT; dec_ok = 1'b1; end
          default: ;
        endcase
      end
      OP_I: begin
        dec_imm = 1'b1;
        case (f3)
          F3_ADDSUB: begin dec_ctrl = ALU_ADD; dec_ok = 1'b1; end
          F3_AND:    begin dec_ctrl = ALU_AND; dec_ok = 1'b1; end
          F3_OR:     begin dec_ctrl = ALU_OR;  dec_ok = 1'b1; end
          F3_SLT:    begin dec_ctrl = ALU_SLT; dec_ok = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Illegal ops carry zeroed indices so a held one is never refreshed by write-back.
    dec_a   = dec_ok ? rs1_data : '0;
    dec_b   = !dec_ok ? '0 : (dec_imm ? instr[27:20] : rs2_data);
    dec_rd  = dec_ok ? instr[11:7] : '0;
    dec_rs1 = dec_ok ? rs1 : '0;
    dec_rs2 = (dec_ok && !dec_imm) ? rs2 : '0;
  end

  logic [4:0] hold_rs1, hold_rs2;
  logic       hold_imm;
  logic       accept, drain, stall;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUctrl   <= '0;
      A         <= '0;
      B         <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
      hold_rs1  <= '0;
      hold_rs2  <= '0;
      hold_imm  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ALUctrl   <= dec_ctrl;
      A         <= dec_a;
      B         <= dec_b;
      rd        <= dec_rd;
      illegal   <= !dec_ok;
      hold_rs1  <= dec_rs1;
      hold_rs2  <= dec_rs2;
      hold_imm  <= dec_imm || !dec_ok;
    end else if (drain) begin
      out_valid <= 1'b0;
    end else if (stall && wb_en) begin
      // Keep stalled operands coherent with the register file.
      if (hold_rs1 != '0 && wb_addr == hold_rs1) A <= wb_data;
      if (!hold_imm && hold_rs2 != '0 && wb_addr == hold_rs2) B <= wb_data;
    end
  end

`ifdef RV8_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (drain) begin
      if (issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
      if (illegal && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rv8_alu_issue_stage.sv
// Self-checking bench: directed test-plan cases plus random traffic against a behavioural model.
module tb_rv8_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
  logic [31:0] instr = '0;
  logic [4:0]  wb_addr = '0;
  logic [7:0]  wb_data = '0;
  logic        in_ready, out_valid, illegal;
  logic [3:0]  ALUctrl;
  logic [7:0]  A, B;
  logic [4:0]  rd;
`ifdef RV8_ISSUE_STATS_EN
  logic [15:0] issued_cnt, illegal_cnt;
`endif

  always #5 clk = ~clk;

  rv8_alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .ALUctrl(ALUctrl), .A(A), .B(B), .rd(rd), .illegal(illegal)
`ifdef RV8_ISSUE_STATS_EN
    , .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  int errors = 0, checks = 0;
  bit done = 1'b0;

  // Behavioural model: architectural registers plus the one operation in flight.
  logic [7:0]  m_regs [32];
  logic        m_v, m_ill, m_imm;
  logic [3:0]  m_c;
  logic [7:0]  m_a, m_b;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [15:0] m_iss, m_illc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] s2, s1,
                                       input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] s1,
                                       input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'b0010011};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_v = 0; m_ill = 0; m_imm = 0; m_c = 0; m_a = 0; m_b = 0;
    m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_iss = 0; m_illc = 0;
  endtask

  // Architectural read as seen in the current cycle, including a same-cycle write.
  function automatic logic [7:0] rd_reg(input logic [4:0] r);
    if (r == 0) return 8'h00;
    if (wb_en && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_decode();
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    op = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    m_c = 4'd15; m_imm = 0;
    if (op == 7'h33) begin
      case ({f7, f3})
        {7'h00, 3'd0}: m_c = 4'd2;
        {7'h20, 3'd0}: m_c = 4'd6;
        {7'h00, 3'd7}: m_c = 4'd0;
        {7'h00, 3'd6}: m_c = 4'd1;
        {7'h00, 3'd2}: m_c = 4'd7;
        default: ;
      endcase
    end else if (op == 7'h13) begin
      m_imm = 1;
      case (f3)
        3'd0: m_c = 4'd2;
        3'd7: m_c = 4'd0;
        3'd6: m_c = 4'd1;
        3'd2: m_c = 4'd7;
        default: ;
      endcase
    end
    m_v = 1;
    m_ill = (m_c == 4'd15);
    if (m_ill) begin
      m_a = 0; m_b = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    end else begin
      m_rs1 = instr[19:15]; m_rs2 = instr[24:20]; m_rd = instr[11:7];
      m_a = rd_reg(m_rs1);
      m_b = m_imm ? instr[27:20] : rd_reg(m_rs2);
    end
  endtask

  task automatic model_update();
    bit acc, drn;
    if (rst) begin model_reset(); return; end
    acc = in_valid && (!m_v || out_ready);
    drn = m_v && out_ready;
    if (drn) begin
      if (m_iss != 16'hFFFF) m_iss++;
      if (m_ill && m_illc != 16'hFFFF) m_illc++;
    end
    if (acc) model_decode();
    else if (drn) m_v = 0;
    else if (m_v && wb_en && wb_addr != 0) begin
      if (wb_addr == m_rs1) m_a = wb_data;
      if (!m_imm && !m_ill && wb_addr == m_rs2) m_b = wb_data;
    end
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic we, input logic [4:0] wa, input logic [7:0] wd);
    in_valid = iv; instr = ins; out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] s1, s2, d;
    logic [2:0] f3s [4];
    f3s[0] = 3'd0; f3s[1] = 3'd7; f3s[2] = 3'd6; f3s[3] = 3'd2;
    s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 4))
      0: return r_op(7'h00, s2, s1, f3s[$urandom_range(0, 3)], d);
      1: return r_op(7'h20, s2, s1, 3'd0, d);
      2: return i_op(12'($urandom), s1, f3s[$urandom_range(0, 3)], d);
      3: return r_op(7'($urandom), s2, s1, 3'($urandom), d);
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      chk("in_ready", in_ready, !m_v || out_ready);
      chk("out_valid", out_valid, m_v);
      if (m_v) begin
        chk("ALUctrl", ALUctrl, m_c);
        chk("A", A, m_a);
        chk("B", B, m_b);
        chk("rd", rd, m_rd);
        chk("illegal", illegal, m_ill);
      end
`ifdef RV8_ISSUE_STATS_EN
      chk("issued_cnt", issued_cnt, m_iss);
      chk("illegal_cnt", illegal_cnt, m_illc);
`endif
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ALUctrl", ALUctrl, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_rd", rd, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    set_in(0, 0, 1, 1, 5'd1, 8'd5); step();
    set_in(0, 0, 1, 1, 5'd2, 8'd2); step();
    set_in(1, 32'h002081B3, 1, 0, 0, 0); step();
    chk("add_valid", out_valid, 1); chk("add_ctrl", ALUctrl, 2);
    chk("add_A", A, 5); chk("add_B", B, 2); chk("add_rd", rd, 3);

    set_in(1, 32'h402081B3, 1, 0, 0, 0); step();
    chk("sub_ctrl", ALUctrl, 6); chk("sub_A", A, 5); chk("sub_B", B, 2);

    set_in(1, 32'h0070F213, 1, 0, 0, 0); step();
    chk("andi_ctrl", ALUctrl, 0); chk("andi_B", B, 7); chk("andi_rd", rd, 4);

    set_in(1, 32'h002081B3, 1, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 5'd1, 8'd9); step();
    chk("stall_A", A, 9); chk("stall_ctrl", ALUctrl, 2);
    chk("stall_B", B, 2); chk("stall_rd", rd, 3); chk("stall_in_ready", in_ready, 0);
    set_in(0, 0, 1, 0, 0, 0); step();
    chk("release_one_xfer", out_valid, 0);

    set_in(1, 32'h000082B3, 1, 1, 5'd1, 8'd77); step();
    chk("bypass_A", A, 77); chk("bypass_B", B, 0); chk("bypass_rd", rd, 5);
    set_in(0, 0, 1, 1, 5'd0, 8'd44); step();
    set_in(1, 32'h00000333, 1, 0, 0, 0); step();
    chk("x0_A", A, 0); chk("x0_B", B, 0);

    set_in(1, 32'h0000007F, 1, 0, 0, 0); step();
    chk("ill_ctrl", ALUctrl, 15); chk("ill_flag", illegal, 1); chk("ill_rd", rd, 0);
    set_in(0, 0, 1, 0, 0, 0); step();
`ifdef RV8_ISSUE_STATS_EN
    chk("stats_illegal", illegal_cnt, 1);
    chk("stats_issued", issued_cnt, 7);
`endif

    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 8'($urandom));
      step();
    end

    set_in(1, 32'h002081B3, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    model_reset();
    #1 chk("midrst_out_valid", out_valid, 0);
    step();
    #1 rst = 1'b0;
    set_in(1, 32'h002081B3, 1, 0, 0, 0); step();
    chk("post_rst_A", A, 0); chk("post_rst_B", B, 0);
    set_in(0, 0, 1, 0, 0, 0); step();

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
